// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe: upstream instruction entry and downstream
// extended-immediate entry. The DUT uses the slave side; the producer/consumer uses master.
interface imm_extend_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      inst;
    logic [3:0]       imm_type;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    modport master (
        output in_valid, inst, imm_type, in_tag, out_ready,
        input  in_ready, out_valid, imm, out_tag, out_illegal
    );

    modport slave (
        input  in_valid, inst, imm_type, in_tag, out_ready,
        output in_ready, out_valid, imm, out_tag, out_illegal
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// Immediate extraction/extension stage followed by a 2-entry skid FIFO.
// Outputs come straight from the head entry registers; in_ready depends only on occupancy.
module imm_extend_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    imm_extend_pipe_if.slave bus,
    output logic [CNT_W-1:0] illegal_cnt
);

    logic [63:0]      ext64;
    logic             ext_illegal;
    logic [XLEN-1:0]  imm_new;

    logic [1:0]       count_q, count_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [XLEN-1:0]  imm_mem_q [2];
    logic [XLEN-1:0]  imm_mem_d [2];
    logic [TAG_W-1:0] tag_mem_q [2];
    logic [TAG_W-1:0] tag_mem_d [2];
    logic             ill_mem_q [2];
    logic             ill_mem_d [2];
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             in_ready_int;
    logic             push;
    logic             pop;

    // Build everything at 64 bits and truncate, so XLEN=32 needs no special widths.
    always_comb begin
        ext64       = '0;
        ext_illegal = 1'b0;
        case (bus.imm_type)
            4'd0: ext64 = '0;
            4'd1: ext64 = {59'b0, bus.inst[14:10]};
            4'd2: begin
                if (XLEN == 64) ext64 = {58'b0, bus.inst[15:10]};
                else            ext_illegal = 1'b1;
            end
            4'd3: ext64 = {{52{bus.inst[21]}}, bus.inst[21:10]};
            4'd4: ext64 = {52'b0, bus.inst[21:10]};
            4'd5: ext64 = {{32{bus.inst[24]}}, bus.inst[24:5], 12'b0};
            4'd6: ext64 = {{46{bus.inst[25]}}, bus.inst[25:10], 2'b0};
            4'd7: ext64 = {{36{bus.inst[9]}}, bus.inst[9:0], bus.inst[25:10], 2'b0};
            4'd8: ext64 = {{48{bus.inst[23]}}, bus.inst[23:10], 2'b0};
            default: ext_illegal = 1'b1;
        endcase
    end

    assign imm_new      = ext64[XLEN-1:0];
    assign in_ready_int = (count_q != 2'd2);
    assign push         = bus.in_valid && in_ready_int && !flush;
    assign pop          = (count_q != 2'd0) && bus.out_ready && !flush;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        cnt_d    = cnt_q;
        for (int i = 0; i < 2; i++) begin
            imm_mem_d[i] = imm_mem_q[i];
            tag_mem_d[i] = tag_mem_q[i];
            ill_mem_d[i] = ill_mem_q[i];
        end
        if (push) begin
            imm_mem_d[wr_ptr_q] = imm_new;
            tag_mem_d[wr_ptr_q] = bus.in_tag;
            ill_mem_d[wr_ptr_q] = ext_illegal;
            if (ext_illegal && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        // Flush empties the buffer; stale slot contents are harmless once count is 0.
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
            for (int i = 0; i < 2; i++) begin
                imm_mem_q[i] <= '0;
                tag_mem_q[i] <= '0;
                ill_mem_q[i] <= 1'b0;
            end
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            for (int i = 0; i < 2; i++) begin
                imm_mem_q[i] <= imm_mem_d[i];
                tag_mem_q[i] <= tag_mem_d[i];
                ill_mem_q[i] <= ill_mem_d[i];
            end
        end
    end

    assign bus.in_ready    = in_ready_int;
    assign bus.out_valid   = (count_q != 2'd0);
    assign bus.imm         = imm_mem_q[rd_ptr_q];
    assign bus.out_tag     = tag_mem_q[rd_ptr_q];
    assign bus.out_illegal = ill_mem_q[rd_ptr_q];
    assign illegal_cnt     = cnt_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench: three DUTs (XLEN 32, XLEN 64, XLEN 64 with a 2-bit counter) share one
// stimulus stream; expected entries are queued on push and compared on pop.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic [31:0] inst;
    logic [3:0]  imm_type;
    logic [7:0]  in_tag;
    logic        out_ready;

    logic [15:0] cnt32_o, cnt64_o;
    logic [1:0]  cnt2_o;

    always #5 clk = ~clk;

    imm_extend_pipe_if #(.XLEN(32), .TAG_W(8)) b32 ();
    imm_extend_pipe_if #(.XLEN(64), .TAG_W(8)) b64 ();
    imm_extend_pipe_if #(.XLEN(64), .TAG_W(8)) bc2 ();

    assign b32.in_valid = in_valid;  assign b64.in_valid = in_valid;  assign bc2.in_valid = in_valid;
    assign b32.inst     = inst;      assign b64.inst     = inst;      assign bc2.inst     = inst;
    assign b32.imm_type = imm_type;  assign b64.imm_type = imm_type;  assign bc2.imm_type = imm_type;
    assign b32.in_tag   = in_tag;    assign b64.in_tag   = in_tag;    assign bc2.in_tag   = in_tag;
    assign b32.out_ready = out_ready; assign b64.out_ready = out_ready; assign bc2.out_ready = out_ready;

    imm_extend_pipe #(.XLEN(32), .TAG_W(8), .CNT_W(16)) dut32 (
        .clk(clk), .rstn(rstn), .flush(flush), .bus(b32), .illegal_cnt(cnt32_o));
    imm_extend_pipe #(.XLEN(64), .TAG_W(8), .CNT_W(16)) dut64 (
        .clk(clk), .rstn(rstn), .flush(flush), .bus(b64), .illegal_cnt(cnt64_o));
    imm_extend_pipe #(.XLEN(64), .TAG_W(8), .CNT_W(2)) dutc2 (
        .clk(clk), .rstn(rstn), .flush(flush), .bus(bc2), .illegal_cnt(cnt2_o));

    typedef struct packed {
        logic [31:0] inst;
        logic [3:0]  typ;
        logic [7:0]  tag;
    } entry_t;

    entry_t      q[$];
    int          errors = 0;
    int          checks = 0;
    int          cnt32_m = 0;
    int          cnt64_m = 0;
    bit          stall_prev = 0;
    logic [31:0] prev_imm32;
    logic [63:0] prev_imm64;
    logic [7:0]  prev_tag;
    logic        prev_ill32, prev_ill64;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [3:0] t, input bit x64);
        logic [63:0] r;
        r = '0;
        case (t)
            4'd1: r = 64'(i[14:10]);
            4'd2: r = x64 ? 64'(i[15:10]) : 64'd0;
            4'd3: r = {{52{i[21]}}, i[21:10]};
            4'd4: r = 64'(i[21:10]);
            4'd5: r = {{32{i[24]}}, i[24:5], 12'h000};
            4'd6: r = {{46{i[25]}}, i[25:10], 2'b00};
            4'd7: r = {{36{i[9]}}, i[9:0], i[25:10], 2'b00};
            4'd8: r = {{48{i[23]}}, i[23:10], 2'b00};
            default: r = '0;
        endcase
        if (!x64) r = {32'h0, r[31:0]};
        return r;
    endfunction

    function automatic bit ref_ill(input logic [3:0] t, input bit x64);
        return (t > 4'd8) || (t == 4'd2 && !x64);
    endfunction

    // One clock cycle: drive, sample mid-cycle, update the model, advance past the edge.
    task automatic cycle(input bit v, input logic [31:0] i, input logic [3:0] t,
                         input logic [7:0] g, input bit r, input bit fl, output bit acc);
        entry_t e;
        bit     full;
        bit     nonempty;
        in_valid = v; inst = i; imm_type = t; in_tag = g; out_ready = r; flush = fl;
        #4;
        acc = 1'b0;
        if (rstn) begin
            nonempty = (q.size() != 0);
            full     = (q.size() >= 2);
            check("valid32", b32.out_valid, nonempty);
            check("valid64", b64.out_valid, nonempty);
            check("validc2", bc2.out_valid, nonempty);
            check("ready32", b32.in_ready, !full);
            check("ready64", b64.in_ready, !full);
            check("cnt32", cnt32_o, 64'(cnt32_m));
            check("cnt64", cnt64_o, 64'(cnt64_m));
            check("cnt_c2", cnt2_o, 64'((cnt64_m > 3) ? 3 : cnt64_m));
            if (stall_prev) begin
                check("hold_imm32", b32.imm, prev_imm32);
                check("hold_imm64", b64.imm, prev_imm64);
                check("hold_tag", b64.out_tag, prev_tag);
                check("hold_ill32", b32.out_illegal, prev_ill32);
                check("hold_ill64", b64.out_illegal, prev_ill64);
            end
            prev_imm32 = b32.imm; prev_imm64 = b64.imm; prev_tag = b64.out_tag;
            prev_ill32 = b32.out_illegal; prev_ill64 = b64.out_illegal;
            stall_prev = nonempty && !r && !fl;
            if (nonempty && r && !fl) begin
                e = q.pop_front();
                check("imm32", b32.imm, ref_imm(e.inst, e.typ, 1'b0));
                check("imm64", b64.imm, ref_imm(e.inst, e.typ, 1'b1));
                check("imm_c2", bc2.imm, ref_imm(e.inst, e.typ, 1'b1));
                check("tag32", b32.out_tag, e.tag);
                check("tag64", b64.out_tag, e.tag);
                check("ill32", b32.out_illegal, ref_ill(e.typ, 1'b0));
                check("ill64", b64.out_illegal, ref_ill(e.typ, 1'b1));
                $display("pop tag=%h type=%0d inst=%h imm64=%h ill64=%0b", e.tag, e.typ, e.inst,
                         b64.imm, b64.out_illegal);
            end
            if (v && !full && !fl) begin
                e.inst = i; e.typ = t; e.tag = g;
                q.push_back(e);
                acc = 1'b1;
                if (ref_ill(t, 1'b0)) cnt32_m++;
                if (ref_ill(t, 1'b1)) cnt64_m++;
            end
            if (fl) q.delete();
        end
        @(posedge clk);
        #1;
        if (!rstn) begin
            q.delete();
            cnt32_m = 0; cnt64_m = 0; stall_prev = 0;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, b64.out_valid, 1'b0);
        check({tag, "_imm32"}, b32.imm, 64'd0);
        check({tag, "_imm64"}, b64.imm, 64'd0);
        check({tag, "_tag"}, b64.out_tag, 8'd0);
        check({tag, "_ill"}, b32.out_illegal, 1'b0);
        check({tag, "_cnt"}, cnt64_o, 16'd0);
        check({tag, "_ready"}, b32.in_ready, 1'b1);
    endtask

    initial begin
        bit acc;
        int accepted;
        int cyc;
        logic [31:0] ri;

        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; inst = '0; imm_type = '0;
        in_tag = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rstn = 1'b1;

        // Illegal codes and counter saturation
        for (int k = 0; k < 3; k++) cycle(1, $urandom, 4'd12, 8'(k + 1), 1, 0, acc);
        cycle(1, $urandom, 4'd4, 8'h04, 1, 0, acc);
        repeat (2) cycle(0, 0, 0, 0, 1, 0, acc);
        check("ill_cnt3", cnt64_o, 16'd3);
        for (int k = 0; k < 2; k++) cycle(1, $urandom, 4'd9, 8'(k + 5), 1, 0, acc);
        repeat (2) cycle(0, 0, 0, 0, 1, 0, acc);
        check("ill_cnt5", cnt64_o, 16'd5);
        check("ill_sat", cnt2_o, 2'd3);

        // SI12 all-ones, one-cycle latency into an empty buffer
        cycle(1, 32'h003F_FC00, 4'd3, 8'h32, 1, 0, acc);
        check("si12_valid", b32.out_valid, 1'b1);
        check("si12_imm", b32.imm, 32'hFFFF_FFFF);
        check("si12_ill", b32.out_illegal, 1'b0);
        cycle(0, 0, 0, 0, 1, 0, acc);

        // SI20 and SI26 sign extension at XLEN=64
        cycle(1, 32'h0100_0000, 4'd5, 8'h50, 0, 0, acc);
        check("si20_imm", b64.imm, 64'hFFFF_FFFF_8000_0000);
        cycle(0, 0, 0, 0, 1, 0, acc);
        cycle(1, 32'h0000_0200, 4'd7, 8'h70, 0, 0, acc);
        check("si26_imm", b64.imm, 64'hFFFF_FFFF_F800_0000);
        cycle(0, 0, 0, 0, 1, 0, acc);

        // Backpressure: tags 1,2 fill the buffer, tag 3 stalls until space frees
        cycle(1, $urandom, 4'd1, 8'h01, 0, 0, acc);
        cycle(1, $urandom, 4'd6, 8'h02, 0, 0, acc);
        check("full_ready", b32.in_ready, 1'b0);
        ri = $urandom;
        cyc = 0;
        do begin
            cycle(1, ri, 4'd8, 8'h03, 1, 0, acc);
            cyc++;
        end while (!acc && cyc < 10);
        check("tag3_accepted", acc, 1'b1);
        repeat (4) cycle(0, 0, 0, 0, 1, 0, acc);
        check("drained", b64.out_valid, 1'b0);

        // Flush with a full buffer and a valid input
        cycle(1, $urandom, 4'd3, 8'hA1, 0, 0, acc);
        cycle(1, $urandom, 4'd11, 8'hA2, 0, 0, acc);
        cycle(1, $urandom, 4'd10, 8'hA3, 0, 1, acc);
        check("flush_valid", b64.out_valid, 1'b0);
        check("flush_ready", b64.in_ready, 1'b1);
        check("flush_cnt", cnt64_o, 16'(cnt64_m));
        repeat (2) cycle(0, 0, 0, 0, 1, 0, acc);

        // Random traffic across all codes
        accepted = 0;
        for (int c = 0; c < 60000 && accepted < 10000; c++) begin
            cycle(($urandom % 4) != 0, $urandom, 4'($urandom % 16), 8'($urandom),
                  ($urandom % 3) != 0, ($urandom % 250) == 0, acc);
            if (acc) accepted++;
        end
        check("rand_count", accepted >= 10000, 1'b1);
        repeat (3) cycle(0, 0, 0, 0, 1, 0, acc);

        // Reset mid-operation beats flush and push
        cycle(1, 32'hFFFF_FFFF, 4'd3, 8'hC1, 0, 0, acc);
        cycle(1, 32'hFFFF_FFFF, 4'd13, 8'hC2, 0, 0, acc);
        rstn = 1'b0;
        cycle(1, 32'hFFFF_FFFF, 4'd14, 8'hC3, 0, 1, acc);
        rstn = 1'b1;
        check_reset_state("midreset");
        repeat (2) cycle(0, 0, 0, 0, 1, 0, acc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
